// File: rtl/side_scheduler.sv
// Purpose: rotates a single green among N side approaches, with an all-red gap between greens.
// Latency: next is latched on the following edge; green ends at dwell MIN_GREEN-1; then CLEAR red cycles.
// Backpressure: none; req/next are sampled levels, and an early next is held in pending until consumed.
//
// Ports:
//   clk      - sole clock, rising edge
//   reset    - synchronous active-low reset
//   req      - per-side demand, bit i = side i waiting
//   next     - request to end the current green (pulse or level)
//   side     - one-hot green, all-zero during clearance
//   idx      - active side, or upcoming side while clearing
//   clearing - high in every all-red cycle
//   pending  - an accepted next is waiting for the minimum dwell
module side_scheduler #(
  parameter int N         = 4,
  parameter int MIN_GREEN = 8,
  parameter int CLEAR     = 2,
  localparam int IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          next,
  output logic [N-1:0]  side,
  output logic [IW-1:0] idx,
  output logic          clearing,
  output logic          pending
);

  localparam int DW = (MIN_GREEN > 1) ? $clog2(MIN_GREEN) : 1;
  localparam int CW = (CLEAR > 1) ? $clog2(CLEAR) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLEAR - 1);

  typedef enum logic {GREEN, CLR} state_t;

  state_t        state;
  logic [DW-1:0] dwell;
  logic [CW-1:0] clr_cnt;

  logic [IW-1:0] tgt;
  logic          tgt_vld;
  logic          advance;
  logic [IW:0]   pos_w;
  logic [IW-1:0] pos;

  // Round-robin search starting just after the current side. Walking k from
  // far to near lets the nearest requester overwrite the result; k never
  // reaches 0, so the current side is never chosen.
  always_comb begin
    tgt     = '0;
    tgt_vld = 1'b0;
    pos_w   = '0;
    pos     = '0;
    for (int k = N - 1; k >= 1; k--) begin
      pos_w = {1'b0, idx} + (IW + 1)'(k);
      if (pos_w >= (IW + 1)'(N)) begin
        pos_w = pos_w - (IW + 1)'(N);
      end
      pos = pos_w[IW-1:0];
      if (req[pos]) begin
        tgt     = pos;
        tgt_vld = 1'b1;
      end
    end
  end

  // A next arriving in the cycle the dwell completes advances immediately,
  // without first passing through pending.
  assign advance = (state == GREEN) && (pending || next) && (dwell == DWELL_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= GREEN;
      idx      <= '0;
      side     <= N'(1);
      clearing <= 1'b0;
      pending  <= 1'b0;
      dwell    <= '0;
      clr_cnt  <= '0;
    end else begin
      case (state)
        GREEN: begin
          if (dwell != DWELL_MAX) begin
            dwell <= dwell + 1'b1;
          end
          if (advance) begin
            pending <= 1'b0;
            // With no other requester the green simply continues on the
            // same side and the dwell stays saturated.
            if (tgt_vld) begin
              state    <= CLR;
              idx      <= tgt;
              side     <= '0;
              clearing <= 1'b1;
              clr_cnt  <= '0;
            end
          end else if (next) begin
            pending <= 1'b1;
          end
        end
        CLR: begin
          // Target is already latched in idx; req and next are ignored here.
          if (clr_cnt == CLR_LAST) begin
            state    <= GREEN;
            side     <= N'(1) << idx;
            clearing <= 1'b0;
            dwell    <= '0;
            clr_cnt  <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= GREEN;
      endcase
    end
  end

endmodule

// File: tb/tb_side_scheduler.sv
// Purpose: self-checking bench for side_scheduler (N=4, MIN_GREEN=3, CLEAR=2).
// Latency: expected outputs are queued when a cycle's inputs are driven, then compared mid-cycle.
// Backpressure: not applicable; the bench drives req/next/reset directly every cycle.
module tb_side_scheduler;

  localparam int N         = 4;
  localparam int MIN_GREEN = 3;
  localparam int CLEAR     = 2;
  localparam int IW        = $clog2(N);

  logic          clk;
  logic          reset;
  logic [N-1:0]  req;
  logic          next;
  logic [N-1:0]  side;
  logic [IW-1:0] idx;
  logic          clearing;
  logic          pending;

  int total = 0;
  int bad   = 0;

  // Scoreboard entry: {side[3:0], idx[1:0], clearing, pending}
  logic [7:0] exp_q [$];

  side_scheduler #(
    .N(N),
    .MIN_GREEN(MIN_GREEN),
    .CLEAR(CLEAR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .next(next),
    .side(side),
    .idx(idx),
    .clearing(clearing),
    .pending(pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time=%0t want end before 200000", $time);
    $fatal(1);
  end

  // Applies one reset edge; returns at posedge+1 of cycle 0 with reset still low.
  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    next  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    logic [7:0] want;
    reset = 1'b0;
    req   = 4'b1111;
    next  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      exp_q.push_back(8'b0001_00_0_0);
      @(negedge clk);
      got  = {side, idx, clearing, pending};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset_state cyc=%0d got {side,idx,clr,pend}=%b want %b", k, got, want);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_advance();
    logic [5:0] stim [7] = '{6'b1_0010_1, 6'b1_0010_0, 6'b1_0010_0, 6'b1_0010_0,
                             6'b1_0010_0, 6'b1_0010_0, 6'b1_0010_0};
    logic [7:0] expv [7] = '{8'b0001_00_0_0, 8'b0001_00_0_1, 8'b0001_00_0_1, 8'b0000_01_1_0,
                             8'b0000_01_1_0, 8'b0010_01_0_0, 8'b0010_01_0_0};
    logic [7:0] got;
    logic [7:0] want;
    do_reset();
    for (int k = 0; k < $size(stim); k++) begin
      {reset, req, next} = stim[k];
      exp_q.push_back(expv[k]);
      @(negedge clk);
      got  = {side, idx, clearing, pending};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL basic_advance cyc=%0d got {side,idx,clr,pend}=%b want %b", k, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_skip_wrap();
    logic [5:0] stim [11] = '{6'b1_0100_1, 6'b1_0100_0, 6'b1_0100_0, 6'b1_0100_0,
                              6'b1_0100_0, 6'b1_0011_1, 6'b1_0011_0, 6'b1_0011_0,
                              6'b1_0011_0, 6'b1_0011_0, 6'b1_0011_0};
    logic [7:0] expv [11] = '{8'b0001_00_0_0, 8'b0001_00_0_1, 8'b0001_00_0_1, 8'b0000_10_1_0,
                              8'b0000_10_1_0, 8'b0100_10_0_0, 8'b0100_10_0_1, 8'b0100_10_0_1,
                              8'b0000_00_1_0, 8'b0000_00_1_0, 8'b0001_00_0_0};
    logic [7:0] got;
    logic [7:0] want;
    do_reset();
    for (int k = 0; k < $size(stim); k++) begin
      {reset, req, next} = stim[k];
      exp_q.push_back(expv[k]);
      @(negedge clk);
      got  = {side, idx, clearing, pending};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL skip_wrap cyc=%0d got {side,idx,clr,pend}=%b want %b", k, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Also covers a next landing on an already-saturated dwell (immediate advance).
  task automatic test_no_demand();
    logic [5:0] stim [10] = '{6'b1_0001_1, 6'b1_0001_0, 6'b1_0001_0, 6'b1_0001_0,
                              6'b1_0001_1, 6'b1_0001_0, 6'b1_0011_1, 6'b1_0011_0,
                              6'b1_0011_0, 6'b1_0011_0};
    logic [7:0] expv [10] = '{8'b0001_00_0_0, 8'b0001_00_0_1, 8'b0001_00_0_1, 8'b0001_00_0_0,
                              8'b0001_00_0_0, 8'b0001_00_0_0, 8'b0001_00_0_0, 8'b0000_01_1_0,
                              8'b0000_01_1_0, 8'b0010_01_0_0};
    logic [7:0] got;
    logic [7:0] want;
    do_reset();
    for (int k = 0; k < $size(stim); k++) begin
      {reset, req, next} = stim[k];
      exp_q.push_back(expv[k]);
      @(negedge clk);
      got  = {side, idx, clearing, pending};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL no_demand cyc=%0d got {side,idx,clr,pend}=%b want %b", k, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_clr_ignores();
    logic [5:0] stim [10] = '{6'b1_0010_1, 6'b1_0010_0, 6'b1_0010_0, 6'b1_1000_1,
                              6'b1_1000_1, 6'b1_1000_0, 6'b1_1000_0, 6'b1_1000_0,
                              6'b1_1000_0, 6'b1_1000_0};
    logic [7:0] expv [10] = '{8'b0001_00_0_0, 8'b0001_00_0_1, 8'b0001_00_0_1, 8'b0000_01_1_0,
                              8'b0000_01_1_0, 8'b0010_01_0_0, 8'b0010_01_0_0, 8'b0010_01_0_0,
                              8'b0010_01_0_0, 8'b0010_01_0_0};
    logic [7:0] got;
    logic [7:0] want;
    do_reset();
    for (int k = 0; k < $size(stim); k++) begin
      {reset, req, next} = stim[k];
      exp_q.push_back(expv[k]);
      @(negedge clk);
      got  = {side, idx, clearing, pending};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL clr_ignores cyc=%0d got {side,idx,clr,pend}=%b want %b", k, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Reset in the second clearance cycle, then reset colliding with an advance.
  task automatic test_reset_priority();
    logic [5:0] stim [10] = '{6'b1_0010_1, 6'b1_0010_0, 6'b1_0010_0, 6'b1_0010_0,
                              6'b0_1111_1, 6'b1_0000_0, 6'b1_1111_0, 6'b0_1111_1,
                              6'b1_0000_0, 6'b1_0000_0};
    logic [7:0] expv [10] = '{8'b0001_00_0_0, 8'b0001_00_0_1, 8'b0001_00_0_1, 8'b0000_01_1_0,
                              8'b0000_01_1_0, 8'b0001_00_0_0, 8'b0001_00_0_0, 8'b0001_00_0_0,
                              8'b0001_00_0_0, 8'b0001_00_0_0};
    logic [7:0] got;
    logic [7:0] want;
    do_reset();
    for (int k = 0; k < $size(stim); k++) begin
      {reset, req, next} = stim[k];
      exp_q.push_back(expv[k]);
      @(negedge clk);
      got  = {side, idx, clearing, pending};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset_priority cyc=%0d got {side,idx,clr,pend}=%b want %b", k, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // next held high with every side requesting: 3 green cycles, 2 red, rotating 0,1,2,3,0.
  task automatic test_back_to_back();
    logic [7:0] got;
    logic [7:0] want;
    logic [7:0] e;
    int g;
    int p;
    do_reset();
    for (int k = 0; k < 25; k++) begin
      reset = 1'b1;
      req   = 4'b1111;
      next  = 1'b1;
      g = (k / 5) % 4;
      p = k % 5;
      if (p < 3) begin
        e = {4'(1 << g), 2'(g), 1'b0, (p != 0)};
      end else begin
        e = {4'b0000, 2'((g + 1) % 4), 1'b1, 1'b0};
      end
      exp_q.push_back(e);
      @(negedge clk);
      got  = {side, idx, clearing, pending};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got {side,idx,clr,pend}=%b want %b", k, got, want);
      end
      total++;
      if (!$onehot0(side) || (side != '0 && clearing)) begin
        bad++;
        $display("FAIL onehot_invariant cyc=%0d got side=%b clearing=%b want at most one bit and not both", k, side, clearing);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    next  = 1'b0;
    test_reset();
    test_basic_advance();
    test_skip_wrap();
    test_no_demand();
    test_clr_ignores();
    test_reset_priority();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
